wb_commit_trace: RTL and testbench

WB_COMMIT_TRACE -- requirements
Module: wb_commit_trace

---
 rtl/wb_commit_trace.sv | 163 ++++++++++++++++
 tb/tb_wb_commit_trace.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_trace.sv
// Writeback commit trace: FIFO of retired register writes, commit counter and
// an optional idle watchdog built only when WB_TRACE_WATCHDOG_EN is defined.
module wb_commit_trace #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned WDOG_LIMIT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     WriteEn_MEM_WB,
    input  logic [4:0]               waddr_out_MEM_WB,
    input  logic [31:0]              wdataMux,
    input  logic                     jal_out_MEM_WB,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [4:0]               out_addr,
    output logic [31:0]              out_data,
    output logic                     out_jal,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [31:0]              commit_cnt,
    output logic                     overflow,
    output logic                     hung
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = 38;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   commit_cnt_q, commit_cnt_d;
    logic          overflow_q, overflow_d;

    logic          commit;
    logic          full;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;

    assign commit = WriteEn_MEM_WB && (waddr_out_MEM_WB != 5'd0);
    assign full   = (count_q == (AW+1)'(DEPTH));
    assign pop    = out_valid && out_ready;
    // When full, a simultaneous pop frees the head slot that wptr now aliases.
    assign push   = commit && (!full || pop);

    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        commit_cnt_d = commit_cnt_q;
        overflow_d   = overflow_q;
        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        if (commit) begin
            commit_cnt_d = commit_cnt_q + 32'd1;
        end
        if (commit && !push) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            commit_cnt_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            commit_cnt_q <= commit_cnt_d;
            overflow_q   <= overflow_d;
        end
    end

    // Storage needs no reset: outputs are gated by out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= {waddr_out_MEM_WB, wdataMux, jal_out_MEM_WB};
        end
    end

    assign head       = mem_q[rptr_q];
    assign out_valid  = (count_q != '0);
    assign out_addr   = out_valid ? head[37:33] : 5'd0;
    assign out_data   = out_valid ? head[32:1]  : 32'd0;
    assign out_jal    = out_valid ? head[0]     : 1'b0;
    assign occupancy  = count_q;
    assign commit_cnt = commit_cnt_q;
    assign overflow   = overflow_q;

`ifdef WB_TRACE_WATCHDOG_EN
    typedef enum logic [1:0] {StIdle, StRun, StHung} wdog_state_e;

    wdog_state_e state_q, state_d;
    logic [15:0] idle_cnt_q, idle_cnt_d;
    logic        hung_q, hung_d;

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (commit) begin
                    state_d    = StRun;
                    idle_cnt_d = '0;
                end
            end
            StRun: begin
                if (commit) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q + 16'd1 == 16'(WDOG_LIMIT)) begin
                    state_d    = StHung;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 16'd1;
                end
            end
            StHung: begin
                if (commit) begin
                    state_d    = StRun;
                    idle_cnt_d = '0;
                end
            end
            default: begin
                state_d    = StIdle;
                idle_cnt_d = '0;
            end
        endcase
        hung_d = (state_d == StHung);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            idle_cnt_q <= '0;
            hung_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            hung_q     <= hung_d;
        end
    end

    assign hung = hung_q;
`else
    logic unused_wdog_limit;
    assign unused_wdog_limit = ^WDOG_LIMIT;
    assign hung = 1'b0;
`endif

endmodule

// File: tb/tb_wb_commit_trace.sv
// Directed bench for wb_commit_trace (DEPTH=8, WDOG_LIMIT=4); hung expectations
// follow whether WB_TRACE_WATCHDOG_EN is defined for the build.
module tb_wb_commit_trace;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wjal;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        out_jal;
    logic [3:0]  occupancy;
    logic [31:0] commit_cnt;
    logic        overflow;
    logic        hung;

    int unsigned n_checks;
    int unsigned n_errors;

`ifdef WB_TRACE_WATCHDOG_EN
    localparam logic HungExp = 1'b1;
`else
    localparam logic HungExp = 1'b0;
`endif

    wb_commit_trace #(
        .DEPTH      (8),
        .WDOG_LIMIT (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .WriteEn_MEM_WB   (we),
        .waddr_out_MEM_WB (waddr),
        .wdataMux         (wdata),
        .jal_out_MEM_WB   (wjal),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_addr         (out_addr),
        .out_data         (out_data),
        .out_jal          (out_jal),
        .occupancy        (occupancy),
        .commit_cnt       (commit_cnt),
        .overflow         (overflow),
        .hung             (hung)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, sample 1 ns later, then idle the inputs.
    task automatic cycle(input logic w, input logic [4:0] a, input logic [31:0] d,
                         input logic j, input logic rdy);
        we        = w;
        waddr     = a;
        wdata     = d;
        wjal      = j;
        out_ready = rdy;
        @(posedge clk);
        #1;
        we        = 1'b0;
        waddr     = 5'd0;
        wdata     = 32'd0;
        wjal      = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        we        = 1'b0;
        waddr     = 5'd0;
        wdata     = 32'd0;
        wjal      = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #2;
        check("rst_occ",   32'(occupancy), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_addr",  32'(out_addr),  32'd0);
        check("rst_cnt",   commit_cnt,     32'd0);
        check("rst_hung",  32'(hung),      32'd0);
        #10;
        rst = 1'b0;

        // Three commits, consumer stalled; first entry visible after one edge
        cycle(1'b1, 5'd1, 32'h11, 1'b0, 1'b0);
        check("lat1_valid", 32'(out_valid), 32'd1);
        check("lat1_data",  out_data,       32'h11);
        cycle(1'b1, 5'd2, 32'h22, 1'b1, 1'b0);
        cycle(1'b1, 5'd3, 32'h33, 1'b0, 1'b0);
        check("three_occ",  32'(occupancy), 32'd3);
        check("three_addr", 32'(out_addr),  32'd1);
        check("three_data", out_data,       32'h11);
        check("three_cnt",  commit_cnt,     32'd3);

        // r0 write is ignored
        cycle(1'b1, 5'd0, 32'hDEAD, 1'b0, 1'b0);
        check("r0_occ", 32'(occupancy), 32'd3);
        check("r0_cnt", commit_cnt,     32'd3);

        // Drain three in order, then outputs go to zero
        for (int i = 0; i < 3; i++) begin
            check("drain3_addr", 32'(out_addr), 32'(i + 1));
            check("drain3_jal",  32'(out_jal),  (i == 1) ? 32'd1 : 32'd0);
            cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        end
        check("empty_valid", 32'(out_valid), 32'd0);
        check("empty_addr",  32'(out_addr),  32'd0);
        check("empty_data",  out_data,       32'd0);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        check("pop_empty_occ", 32'(occupancy), 32'd0);

        // Ten commits into an 8-deep FIFO: last two dropped
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 5'(i + 1), 32'h100 + 32'(i), 1'b0, 1'b0);
        end
        check("ovf_occ",  32'(occupancy), 32'd8);
        check("ovf_flag", 32'(overflow),  32'd1);
        check("ovf_cnt",  commit_cnt,     32'd10);
        for (int i = 0; i < 8; i++) begin
            check("ovf_drain_addr", 32'(out_addr), 32'(i + 1));
            check("ovf_drain_data", out_data,      32'h100 + 32'(i));
            cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        end
        check("ovf_drained_occ", 32'(occupancy), 32'd0);
        check("ovf_sticky",      32'(overflow),  32'd1);

        // Full FIFO with push and pop every cycle for 20 cycles
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 5'(i + 1), 32'h200 + 32'(i), 1'b0, 1'b0);
        end
        for (int k = 0; k < 20; k++) begin
            check("full_pp_data", out_data, 32'h200 + 32'(k));
            cycle(1'b1, 5'(((8 + k) % 31) + 1), 32'h200 + 32'(8 + k), 1'b0, 1'b1);
            check("full_pp_occ", 32'(occupancy), 32'd8);
        end
        check("full_pp_ovf", 32'(overflow), 32'd0);
        check("full_pp_cnt", commit_cnt,    32'd28);
        for (int i = 0; i < 8; i++) begin
            check("wrap_drain_addr", 32'(out_addr), 32'(((28 - 8 + i) % 31) + 1));
            check("wrap_drain_data", out_data,      32'h200 + 32'(20 + i));
            cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        end

        // Watchdog: silence before the first commit never trips it
        pulse_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        end
        check("preboot_hung", 32'(hung), 32'd0);
        cycle(1'b1, 5'd5, 32'h55, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
            check("wdog_pre_hung", 32'(hung), 32'd0);
        end
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        check("wdog_hung", 32'(hung), 32'(HungExp));
        cycle(1'b1, 5'd6, 32'h66, 1'b0, 1'b0);
        check("wdog_recover", 32'(hung), 32'd0);

        // Reset mid-operation with 5 entries held, overflow and hung set
        pulse_reset();
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, 5'(i + 1), 32'h300 + 32'(i), 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        end
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        check("pre_rst_occ",  32'(occupancy), 32'd5);
        check("pre_rst_ovf",  32'(overflow),  32'd1);
        check("pre_rst_hung", 32'(hung),      32'(HungExp));
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_occ",   32'(occupancy), 32'd0);
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_data",  out_data,       32'd0);
        check("async_rst_cnt",   commit_cnt,     32'd0);
        check("async_rst_ovf",   32'(overflow),  32'd0);
        check("async_rst_hung",  32'(hung),      32'd0);

        // Commit held across an edge while rst is high is not captured
        we    = 1'b1;
        waddr = 5'd7;
        wdata = 32'h77;
        @(posedge clk);
        #1;
        rst = 1'b0;
        we  = 1'b0;
        check("rst_commit_occ", 32'(occupancy), 32'd0);
        check("rst_commit_cnt", commit_cnt,     32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
